// File: rtl/fifo_prog.sv
`default_nettype none
// ============================================================================
// Module   : fifo_prog
// Brief    : Parametrised single-clock FIFO with optional FWFT read mode,
//            programmable almost-full/empty thresholds and sticky errors.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_prog #(
    parameter int DATA_WIDTH = 4,
    parameter int BUF_WIDTH  = 3,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] buf_in,
    input  logic [BUF_WIDTH:0]    almost_full_th,
    input  logic [BUF_WIDTH:0]    almost_empty_th,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] buf_out,
    output logic                  valid,
    output logic [BUF_WIDTH:0]    fifo_counter,
    output logic                  buf_empty,
    output logic                  buf_full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [BUF_WIDTH:0] c_DEPTH = {1'b1, {BUF_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<BUF_WIDTH)-1];
    logic [BUF_WIDTH-1:0]  r_wr_ptr;
    logic [BUF_WIDTH-1:0]  r_rd_ptr;
    logic [BUF_WIDTH:0]    r_count;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    // A pop on a full FIFO frees the slot for a push in the same cycle.
    assign w_rd_acc = rd_en && !buf_empty;
    assign w_wr_acc = wr_en && (!buf_full || w_rd_acc);

    assign fifo_counter = r_count;
    assign buf_empty    = (r_count == '0);
    assign buf_full     = (r_count == c_DEPTH);
    assign almost_full  = (r_count >= almost_full_th);
    assign almost_empty = (r_count <= almost_empty_th);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + BUF_WIDTH'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + BUF_WIDTH'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + (BUF_WIDTH+1)'(1);
                2'b01:   r_count <= r_count - (BUF_WIDTH+1)'(1);
                default: r_count <= r_count;
            endcase
            // A new error event takes priority over a concurrent clear.
            if (wr_en && !w_wr_acc) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (rd_en && !w_rd_acc) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= buf_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign buf_out = r_mem[r_rd_ptr];
            assign valid   = !buf_empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_buf_out;
            logic                  r_valid;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_buf_out <= '0;
                    r_valid   <= 1'b0;
                end else begin
                    r_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_buf_out <= r_mem[r_rd_ptr];
                    end
                end
            end

            assign buf_out = r_buf_out;
            assign valid   = r_valid;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fifo_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_prog
// Brief    : Directed self-checking bench for fifo_prog (standard and FWFT).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_prog;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] buf_in = '0;
    logic [3:0] af_th = 4'd8;
    logic [3:0] ae_th = 4'd0;
    logic       err_clr = 1'b0;

    logic [7:0] s_out, f_out;
    logic       s_valid, f_valid;
    logic [3:0] s_cnt, f_cnt;
    logic       s_empty, s_full, s_af, s_ae, s_ovf, s_unf;
    logic       f_empty, f_full, f_af, f_ae, f_ovf, f_unf;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    fifo_prog #(.DATA_WIDTH(8), .BUF_WIDTH(3), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .buf_in(buf_in),
        .almost_full_th(af_th), .almost_empty_th(ae_th), .err_clr(err_clr),
        .buf_out(s_out), .valid(s_valid), .fifo_counter(s_cnt),
        .buf_empty(s_empty), .buf_full(s_full), .almost_full(s_af),
        .almost_empty(s_ae), .overflow(s_ovf), .underflow(s_unf)
    );

    fifo_prog #(.DATA_WIDTH(8), .BUF_WIDTH(3), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .buf_in(buf_in),
        .almost_full_th(af_th), .almost_empty_th(ae_th), .err_clr(err_clr),
        .buf_out(f_out), .valid(f_valid), .fifo_counter(f_cnt),
        .buf_empty(f_empty), .buf_full(f_full), .almost_full(f_af),
        .almost_empty(f_ae), .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state, sampled before any clock edge.
        #3;
        check("rst_cnt",    32'(s_cnt), 32'd0);
        check("rst_empty",  32'(s_empty), 32'd1);
        check("rst_full",   32'(s_full), 32'd0);
        check("rst_ae",     32'(s_ae), 32'd1);
        check("rst_af_th8", 32'(s_af), 32'd0);
        check("rst_valid",  32'(s_valid), 32'd0);
        check("rst_out",    32'(s_out), 32'd0);
        check("rst_ovf",    32'(s_ovf), 32'd0);
        check("rst_unf",    32'(s_unf), 32'd0);
        check("rst_fvalid", 32'(f_valid), 32'd0);
        af_th = 4'd0;
        #1;
        check("rst_af_th0", 32'(s_af), 32'd1);
        af_th = 4'd8;
        step();
        rst = 1'b0;
        step();

        // Fill 0x10..0x17 then drain in order.
        wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            buf_in = 8'h10 + 8'(i);
            step();
            check("fill_cnt", 32'(s_cnt), 32'(i + 1));
        end
        wr_en = 1'b0;
        check("fill_full", 32'(s_full), 32'd1);
        check("fill_af",   32'(s_af), 32'd1);
        rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("drain_out",   32'(s_out), 32'h10 + 32'(i));
            check("drain_valid", 32'(s_valid), 32'd1);
        end
        rd_en = 1'b0;
        step();
        check("drain_valid_end", 32'(s_valid), 32'd0);
        check("drain_empty",     32'(s_empty), 32'd1);
        check("drain_out_hold",  32'(s_out), 32'h17);

        // Wrap-around: advance pointers by 5, then 6 words across the wrap.
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; buf_in = 8'h50 + 8'(i); step();
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        for (int i = 0; i < 5; i++) step();
        rd_en = 1'b0;
        check("wrap_pre_out", 32'(s_out), 32'h54);
        wr_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            buf_in = 8'hA0 + 8'(i); step();
        end
        wr_en = 1'b0;
        check("wrap_cnt6", 32'(s_cnt), 32'd6);
        rd_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("wrap_out", 32'(s_out), 32'hA0 + 32'(i));
        end
        rd_en = 1'b0;
        check("wrap_cnt0", 32'(s_cnt), 32'd0);

        // Simultaneous push+pop at full.
        wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            buf_in = 8'h20 + 8'(i); step();
        end
        rd_en = 1'b1; buf_in = 8'h99;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        check("sim_full_cnt",   32'(s_cnt), 32'd8);
        check("sim_full_ovf",   32'(s_ovf), 32'd0);
        check("sim_full_out",   32'(s_out), 32'h20);
        check("sim_full_valid", 32'(s_valid), 32'd1);
        rd_en = 1'b1;
        for (int i = 1; i < 8; i++) begin
            step();
            check("sim_drain", 32'(s_out), 32'h20 + 32'(i));
        end
        step();
        check("sim_drain_last", 32'(s_out), 32'h99);
        rd_en = 1'b0;
        check("sim_drain_cnt", 32'(s_cnt), 32'd0);

        // Simultaneous push+pop at empty: only the push is accepted.
        wr_en = 1'b1; rd_en = 1'b1; buf_in = 8'h77;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        check("sim_empty_cnt",   32'(s_cnt), 32'd1);
        check("sim_empty_unf",   32'(s_unf), 32'd1);
        check("sim_empty_valid", 32'(s_valid), 32'd0);
        check("sim_empty_out",   32'(s_out), 32'h99);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("unf_clr", 32'(s_unf), 32'd0);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("sim_empty_pop", 32'(s_out), 32'h77);
        check("sim_empty_cnt0", 32'(s_cnt), 32'd0);

        // Thresholds.
        af_th = 4'd6; ae_th = 4'd2;
        #1;
        check("th_ae_0", 32'(s_ae), 32'd1);
        check("th_af_0", 32'(s_af), 32'd0);
        wr_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            buf_in = 8'h30 + 8'(i);
            step();
            check("th_ae", 32'(s_ae), (i + 1 <= 2) ? 32'd1 : 32'd0);
            check("th_af", 32'(s_af), (i + 1 >= 6) ? 32'd1 : 32'd0);
        end
        wr_en = 1'b0;
        af_th = 4'd8;
        #1;
        check("th_af_change", 32'(s_af), 32'd0);

        // Overflow: 8th word fills, 9th and 10th are rejected.
        wr_en = 1'b1; buf_in = 8'h37; step();
        check("ovf_pre", 32'(s_ovf), 32'd0);
        buf_in = 8'hEE; step();
        wr_en = 1'b0;
        check("ovf_set", 32'(s_ovf), 32'd1);
        check("ovf_cnt", 32'(s_cnt), 32'd8);
        err_clr = 1'b1; step();
        check("ovf_clr", 32'(s_ovf), 32'd0);
        wr_en = 1'b1; buf_in = 8'hEF; step();
        wr_en = 1'b0; err_clr = 1'b0;
        check("ovf_set_wins", 32'(s_ovf), 32'd1);
        rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("ovf_drain", 32'(s_out), 32'h30 + 32'(i));
        end
        rd_en = 1'b0;
        check("ovf_drain_cnt", 32'(s_cnt), 32'd0);
        err_clr = 1'b1; step(); err_clr = 1'b0;

        // FWFT instance: fall-through, acknowledge, then async reset.
        check("fwft_empty_valid", 32'(f_valid), 32'd0);
        wr_en = 1'b1; buf_in = 8'h3C; step();
        wr_en = 1'b0;
        check("fwft_valid", 32'(f_valid), 32'd1);
        check("fwft_out",   32'(f_out), 32'h3C);
        step();
        check("fwft_hold", 32'(f_out), 32'h3C);
        rd_en = 1'b1; step(); rd_en = 1'b0;
        check("fwft_ack_valid", 32'(f_valid), 32'd0);
        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            buf_in = 8'hC0 + 8'(i); step();
        end
        wr_en = 1'b0;
        check("fwft_midfill_cnt", 32'(f_cnt), 32'd3);
        #1 rst = 1'b1;
        #1;
        check("async_rst_fcnt",   32'(f_cnt), 32'd0);
        check("async_rst_fvalid", 32'(f_valid), 32'd0);
        check("async_rst_scnt",   32'(s_cnt), 32'd0);
        step();
        rst = 1'b0;
        wr_en = 1'b1; buf_in = 8'h5A; step();
        buf_in = 8'h5B; step();
        wr_en = 1'b0;
        check("post_rst_fout", 32'(f_out), 32'h5A);
        check("post_rst_fcnt", 32'(f_cnt), 32'd2);
        rd_en = 1'b1; step(); rd_en = 1'b0;
        check("post_rst_sout", 32'(s_out), 32'h5A);
        check("post_rst_fnext", 32'(f_out), 32'h5B);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_prog.md
# fifo_prog

Parametrised synchronous FIFO that succeeds the fixed 4-bit FIFO in the same datapath. It adds configurable data width and depth, an optional first-word-fall-through (FWFT) read mode, run-time programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. It sits between producer and consumer blocks in a single clock domain.

## Interface
- DATA_WIDTH, 4, width of each stored word
- BUF_WIDTH, 3, address bits; depth DEPTH = 2^BUF_WIDTH
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through

- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- wr_en  input  1  push request
- rd_en  input  1  pop request
- buf_in  input  DATA_WIDTH  push data
- almost_full_th  input  BUF_WIDTH+1  almost_full threshold (count)
- almost_empty_th  input  BUF_WIDTH+1  almost_empty threshold (count)
- err_clr  input  1  clears overflow/underflow
- buf_out  output  DATA_WIDTH  read data
- valid  output  1  buf_out holds meaningful data
- fifo_counter  output  BUF_WIDTH+1  number of stored words, 0..DEPTH
- buf_empty, buf_full, almost_full, almost_empty  output  1 each  status flags
- overflow, underflow  output  1 each  sticky error flags

## Operation
- Write accepted (wr_acc) = wr_en && (!buf_full || rd_acc). A pop on a full FIFO frees the slot in the same cycle.
- Read accepted (rd_acc) = rd_en && !buf_empty. A read on an empty FIFO is never accepted, even with a simultaneous write.
- Count update: wr_acc only → +1; rd_acc only → −1; both or neither → unchanged.
- Pointers are BUF_WIDTH bits. wr_ptr advances on wr_acc and rd_ptr advances on rd_acc. Both wrap DEPTH−1 → 0 naturally.
- Memory write: mem[wr_ptr] <= buf_in on wr_acc only.
- Flags are decoded from the registered fifo_counter:
  - buf_empty = (count==0)
  - buf_full = (count==DEPTH)
  - almost_full = (count >= almost_full_th)
  - almost_empty = (count <= almost_empty_th)
  - Thresholds are unsigned and evaluated continuously. A threshold change affects the flags in the same cycle.
- Standard mode (FWFT=0):
  - On rd_acc, buf_out <= mem[rd_ptr] and valid <= 1. Otherwise buf_out holds and valid <= 0.
  - valid is a one-cycle pulse per accepted read.
- FWFT mode (FWFT=1):
  - buf_out = mem[rd_ptr] and valid = !buf_empty.
  - rd_en acts as an acknowledge that pops the head word.
  - buf_out is don't-care while valid=0.
- overflow sets on wr_en && !wr_acc. underflow sets on rd_en && !rd_acc.
- Both error flags are sticky until err_clr. If set and clear coincide, set wins.
- Rejected operations change no pointer, count, memory or buf_out.

## Timing
- Reset (asynchronous, immediate):
  - count=0, pointers=0, buf_out=0 (FWFT=0), valid=0, overflow=0, underflow=0.
  - Consequently buf_empty=1, buf_full=0 and almost_empty=1.
  - almost_full=1 only if almost_full_th==0.
  - Memory contents are not reset.
- Reset asserted mid-operation discards all stored data. The first push after release is read back first.
- Write-to-flag latency: flags and count reflect a push one cycle after the edge that accepts it.
- FWFT=0 read latency: data and valid appear 1 cycle after the accepting edge.
- FWFT=1 read latency: the first word is visible 1 cycle after its push into an empty FIFO; there is no read latency.
- Throughput: one push and one pop per cycle, sustained, at any fill level including full (pop+push) and empty (push only).

## Test plan
- Fill/drain (DATA_WIDTH=8, BUF_WIDTH=3, FWFT=0): push 0x10..0x17 on 8 cycles.
  - Required: buf_full=1 and count=8.
  - Then pop 8 times. Required: buf_out 0x10..0x17 in order, each with a 1-cycle valid, ending with buf_empty=1.
- Wrap-around: push 5, pop 5, then push 6 values 0xA0..0xA5 and pop all 6.
  - Required: order preserved across the pointer wrap; count returns to 0.
- Simultaneous ops:
  - At count=8, wr_en+rd_en: count stays 8, overflow stays 0, oldest word is output.
  - At count=0, wr_en+rd_en: count becomes 1, underflow=1.
- Thresholds: set almost_full_th=6 and almost_empty_th=2, then push 7 words.
  - Required: almost_empty=1 for counts 0..2; almost_full=1 from count 6.
  - Changing almost_full_th to 8 at count 7 drops almost_full in the same cycle.
- Errors: push 9 into depth 8.
  - Required: overflow=1 and the 9th word is not stored.
  - err_clr=1 with no error event clears overflow next cycle; err_clr concurrent with a new overflow keeps it at 1.
- FWFT=1: push 0x3C into an empty FIFO.
  - Required: next cycle valid=1 and buf_out=0x3C with no rd_en.
  - rd_en for one cycle then gives valid=0.
  - Assert rst mid-fill: count=0 and valid=0 immediately, without waiting for a clock edge.
